// File: rtl/bscan_seq_ctrl.sv
// bscan_seq_ctrl: boundary-scan sequencer running EXTEST/INTEST/SAMPLE/BYPASS over two BSR chains
module bscan_seq_ctrl #(
    parameter int CHAIN1_LEN = 8,
    parameter int CHAIN2_LEN = 8,
    parameter int BYPASS_LEN = 2,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       shift_dr1,
    output logic       up_enable1,
    output logic       mode1,
    output logic       sel1,
    output logic       bp_shift1,
    output logic       shift_dr2,
    output logic       up_enable2,
    output logic       mode2,
    output logic       sel2,
    output logic       bp_shift2
);
    if (CHAIN1_LEN < 1 || CHAIN1_LEN > 2**CNT_W-1 || CHAIN2_LEN < 1 || CHAIN2_LEN > 2**CNT_W-1 ||
        BYPASS_LEN < 1 || BYPASS_LEN > 2**CNT_W-1) begin : g_bad_len
        $error("bscan_seq_ctrl: chain/bypass length out of counter range");
    end
    typedef enum logic [2:0] {IDLE, SHIFT1, UPDATE, CAPTURE, SHIFT2, DONE} state_t;
    localparam logic [1:0] OP_EXTEST = 2'd0, OP_INTEST = 2'd1, OP_SAMPLE = 2'd2, OP_BYPASS = 2'd3;
    localparam logic [CNT_W-1:0] L1_LAST = CNT_W'(CHAIN1_LEN - 1);
    localparam logic [CNT_W-1:0] L2_LAST = CNT_W'(CHAIN2_LEN - 1);
    localparam logic [CNT_W-1:0] LB_LAST = CNT_W'(BYPASS_LEN - 1);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, last;
    logic [1:0]       op_q;
    logic             ext, intst, smp, byp, accept;
    assign ext    = op_q == OP_EXTEST;
    assign intst  = op_q == OP_INTEST;
    assign smp    = op_q == OP_SAMPLE;
    assign byp    = op_q == OP_BYPASS;
    assign accept = state == IDLE && start && !abort;
    // SHIFT2 length depends on which chain is routed to the scan output
    assign last = state == SHIFT1 ? L1_LAST : ext ? L2_LAST : byp ? LB_LAST : L1_LAST;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (op == OP_EXTEST || op == OP_INTEST) ? SHIFT1 :
                                             op == OP_SAMPLE ? CAPTURE : SHIFT2;
            SHIFT1:  if (cnt == last) state_nxt = UPDATE;
            UPDATE:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = SHIFT2;
            SHIFT2:  if (cnt == last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) state_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= state_nxt != state ? '0 : cnt + CNT_W'(1);
            op_q  <= accept ? op : op_q;
        end
    end
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign shift_dr1  = state == SHIFT1 || (state == SHIFT2 && (intst || smp));
    assign up_enable1 = state == UPDATE;
    assign mode1      = busy && (ext || intst);
    assign sel1       = !(state == SHIFT2 && (intst || smp));
    assign bp_shift1  = state == SHIFT2 && byp;
    assign shift_dr2  = state == SHIFT2 && ext;
    assign up_enable2 = 1'b0;
    assign mode2      = busy && ext;
    assign sel2       = !(state == SHIFT2 && ext);
    assign bp_shift2  = state == SHIFT2 && (byp || intst);
endmodule

// File: tb/tb_bscan_seq_ctrl.sv
// tb_bscan_seq_ctrl: directed bench for bscan_seq_ctrl at default lengths and with CHAIN1_LEN=4
module tb_bscan_seq_ctrl;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0] op = 2'd0;
    logic       busy, done, shift_dr1, up_enable1, mode1, sel1, bp_shift1;
    logic       shift_dr2, up_enable2, mode2, sel2, bp_shift2;
    logic       busy4, done4, shift_dr14, up_enable14, mode14, sel14, bp_shift14;
    logic       shift_dr24, up_enable24, mode24, sel24, bp_shift24;
    logic [11:0] v, v4;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    bscan_seq_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .abort(abort),
        .busy(busy), .done(done), .shift_dr1(shift_dr1), .up_enable1(up_enable1),
        .mode1(mode1), .sel1(sel1), .bp_shift1(bp_shift1), .shift_dr2(shift_dr2),
        .up_enable2(up_enable2), .mode2(mode2), .sel2(sel2), .bp_shift2(bp_shift2)
    );

    bscan_seq_ctrl #(.CHAIN1_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .op(op), .abort(abort),
        .busy(busy4), .done(done4), .shift_dr1(shift_dr14), .up_enable1(up_enable14),
        .mode1(mode14), .sel1(sel14), .bp_shift1(bp_shift14), .shift_dr2(shift_dr24),
        .up_enable2(up_enable24), .mode2(mode24), .sel2(sel24), .bp_shift2(bp_shift24)
    );

    assign v  = {busy, done, shift_dr1, up_enable1, mode1, sel1, bp_shift1,
                 shift_dr2, up_enable2, mode2, sel2, bp_shift2};
    assign v4 = {busy4, done4, shift_dr14, up_enable14, mode14, sel14, bp_shift14,
                 shift_dr24, up_enable24, mode24, sel24, bp_shift24};

    localparam logic [11:0] IDLE_V = 12'b000001000010;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // bit order: busy done sd1 ue1 m1 sel1 bp1 sd2 ue2 m2 sel2 bp2
    function automatic logic [11:0] exp_vec(input logic [1:0] o, input int ph);
        case (ph)
            1: return o == 2'd0 ? 12'b101011000110 : 12'b101011000010;
            2: return o == 2'd0 ? 12'b100111000110 : 12'b100111000010;
            3: return o == 2'd0 ? 12'b100011000110 : o == 2'd1 ? 12'b100011000010 : 12'b100001000010;
            4: return o == 2'd0 ? 12'b100011010100 : o == 2'd1 ? 12'b101010000011 :
                      o == 2'd2 ? 12'b101000000010 : 12'b100001100011;
            5: return o == 2'd0 ? 12'b110011000110 : o == 2'd1 ? 12'b110011000010 : 12'b110001000010;
            default: return IDLE_V;
        endcase
    endfunction

    // phase 1 SHIFT1, 2 UPDATE, 3 CAPTURE, 4 SHIFT2, 5 DONE, 0 IDLE for cycle n after accept
    function automatic int phase_at(input logic [1:0] o, input int n, input int l1);
        int l2;
        l2 = o == 2'd0 ? 8 : l1;
        if (o <= 2'd1) begin
            if (n <= l1) return 1;
            if (n == l1 + 1) return 2;
            if (n == l1 + 2) return 3;
            if (n <= l1 + 2 + l2) return 4;
            if (n == l1 + 3 + l2) return 5;
            return 0;
        end
        if (o == 2'd2) begin
            if (n == 1) return 3;
            if (n <= 1 + l1) return 4;
            if (n == 2 + l1) return 5;
            return 0;
        end
        if (n <= 2) return 4;
        if (n == 3) return 5;
        return 0;
    endfunction

    task automatic run_op(input logic [1:0] o, input int lat);
        int d, d4;
        d = 0;
        d4 = 0;
        @(negedge clk);
        op = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= lat + 2; n++) begin
            check($sformatf("op%0d_c%0d", o, n), v, exp_vec(o, phase_at(o, n, 8)));
            if (o == 2'd1) check($sformatf("op1_len4_c%0d", n), v4, exp_vec(o, phase_at(o, n, 4)));
            if (done && d == 0) d = n;
            if (done4 && d4 == 0) d4 = n;
            @(negedge clk);
        end
        check($sformatf("op%0d_latency", o), d, lat);
        if (o == 2'd1) check("op1_len4_latency", d4, 11);
    endtask

    initial begin
        int dones;
        #2;
        check("reset_outputs", v, IDLE_V);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_release", v, IDLE_V);

        run_op(2'd0, 19);
        run_op(2'd1, 19);
        run_op(2'd2, 10);
        run_op(2'd3, 3);

        // async reset in SHIFT1 cycle 4
        @(negedge clk);
        op = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("shift1_c4_before_reset", v, exp_vec(2'd0, 1));
        rst = 1'b0;
        #1;
        check("async_reset_outputs", v, IDLE_V);
        check("async_reset_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle_%0d", n), v, IDLE_V);
        end

        // start held across the whole BYPASS op
        dones = 0;
        @(negedge clk);
        op = 2'd3;
        start = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            check($sformatf("held_byp_c%0d", n), v, exp_vec(2'd3, phase_at(2'd3, n, 8)));
            dones += int'(done);
        end
        start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check($sformatf("held_byp_idle_%0d", n), v, IDLE_V);
            dones += int'(done);
        end
        check("held_byp_one_done", dones, 1);

        // abort on SHIFT2 cycle 3 of EXTEST
        dones = 0;
        @(negedge clk);
        op = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_pre_shift2_c3", v, exp_vec(2'd0, 4));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_to_idle", v, IDLE_V);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            dones += int'(done);
        end
        check("abort_no_done", dones, 0);
        check("abort_stays_idle", v, IDLE_V);

        // start and abort together in IDLE
        @(negedge clk);
        op = 2'd3;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", v, IDLE_V);
        @(negedge clk);
        check("start_abort_idle2", v, IDLE_V);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
